inst_fetch: RTL and testbench

Instruction fetch stage. Drives the read side of the instruction memory, absorbs its one-cycle registered read latency, and presents instructions to decode through a valid/ready handshake with a 2-entry buffer. Sits between the PC/redirect logic of the core and the decode stage. Supports branch/jump redirect with flush of all wrong-path words.

---
 rtl/inst_fetch.sv | 143 ++++++++++++++
 tb/tb_inst_fetch.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// inst_fetch -- instruction fetch stage.
//
// Drives the read side of the instruction memory. It absorbs the memory's
// one-cycle registered read latency and hands instructions to decode through
// a 2-entry {data, pc} buffer with a valid/ready handshake. A redirect pulse
// flushes every wrong-path word, including the read still in flight.
//
// Parameters:
//   WORD      instruction width
//   ADDR      word-address width
//   RESET_PC  word address fetched first after reset
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   imem_a          instruction memory word address (always equals pc)
//   imem_w          instruction memory write enable (always 0)
//   imem_q          instruction memory read data, one cycle after imem_a
//   halt            suppresses new issues; an in-flight word still completes
//   redirect_valid  one-cycle pulse: flush and refetch from redirect_pc
//   redirect_pc     redirect target word address
//   inst_valid      buffer head holds a valid instruction
//   inst_ready      decode accepts the head this cycle
//   inst_data       head instruction word
//   inst_pc         word address of the head instruction
//
// Optional feature, macro INST_FETCH_PERF_EN:
//   perf_fetched    +1 per completed handshake (wraps at 2^32)
//   perf_stall      +1 per cycle with inst_valid && !inst_ready (wraps at 2^32)
//   Both reset to 0; a redirect does not clear them.
//
// Handshake: a word moves to decode in every cycle where inst_valid and
// inst_ready are both high. While inst_valid is high and inst_ready is low,
// inst_data and inst_pc hold their values. inst_valid does not depend on
// inst_ready in the same cycle.
module inst_fetch #(
  parameter int          WORD     = 32,
  parameter int          ADDR     = 16,
  parameter int unsigned RESET_PC = 0
) (
  input  logic            clk,
  input  logic            rst,
  output logic [ADDR-1:0] imem_a,
  output logic            imem_w,
  input  logic [WORD-1:0] imem_q,
  input  logic            halt,
  input  logic            redirect_valid,
  input  logic [ADDR-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [WORD-1:0] inst_data,
  output logic [ADDR-1:0] inst_pc
`ifdef INST_FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_stall
`endif
);

  localparam logic [ADDR-1:0] RESET_PC_A = ADDR'(RESET_PC);

  logic [ADDR-1:0] pc;
  logic            inflight;
  logic [ADDR-1:0] inflight_pc;

  logic [WORD-1:0] fifo_data [2];
  logic [ADDR-1:0] fifo_pc   [2];
  logic            rd_ptr;
  logic            wr_ptr;
  logic [1:0]      count;

  logic            pop;
  logic            push;
  logic            issue;
  logic [2:0]      occupancy;

  assign pop  = (count != 2'd0) && inst_ready;
  // A word returning in a redirect cycle is already wrong-path.
  assign push = inflight && !redirect_valid;

  // Credit check: slots already promised (buffered plus in flight), minus the
  // one leaving this cycle, must leave room for one more word.
  assign occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign issue     = !halt && !redirect_valid && (occupancy < 3'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc           <= RESET_PC_A;
      inflight     <= 1'b0;
      inflight_pc  <= '0;
      count        <= 2'd0;
      rd_ptr       <= 1'b0;
      wr_ptr       <= 1'b0;
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
      fifo_pc[0]   <= '0;
      fifo_pc[1]   <= '0;
    end else if (redirect_valid) begin
      pc       <= redirect_pc;
      inflight <= 1'b0;
      count    <= 2'd0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= pc;
        pc          <= pc + 1'b1;
      end
      if (push) begin
        fifo_data[wr_ptr] <= imem_q;
        fifo_pc[wr_ptr]   <= inflight_pc;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign imem_a     = pc;
  assign imem_w     = 1'b0;
  assign inst_valid = (count != 2'd0);
  assign inst_data  = fifo_data[rd_ptr];
  assign inst_pc    = fifo_pc[rd_ptr];

`ifdef INST_FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (pop) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (inst_valid && !inst_ready) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

  localparam int          WORD   = 32;
  localparam int          ADDR   = 16;
  localparam int unsigned RST_PC = 32'h0000_FFFE;
  localparam logic [ADDR-1:0] RST_A = 16'hFFFE;

  // ---------------- clock / reset / signals ----------------
  logic            clk = 1'b0;
  logic            rst;
  logic [ADDR-1:0] imem_a;
  logic            imem_w;
  logic [WORD-1:0] imem_q = '0;
  logic            halt;
  logic            redirect_valid;
  logic [ADDR-1:0] redirect_pc;
  logic            inst_valid;
  logic            inst_ready;
  logic [WORD-1:0] inst_data;
  logic [ADDR-1:0] inst_pc;
`ifdef INST_FETCH_PERF_EN
  logic [31:0]     perf_fetched;
  logic [31:0]     perf_stall;
`endif

  always #5 clk = ~clk;

  inst_fetch #(.WORD(WORD), .ADDR(ADDR), .RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_a         (imem_a),
    .imem_w         (imem_w),
    .imem_q         (imem_q),
    .halt           (halt),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc)
`ifdef INST_FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall)
`endif
  );

  // ---------------- instruction memory model ----------------
  logic [WORD-1:0] mem_seed;

  function automatic logic [WORD-1:0] mem_fn(input logic [ADDR-1:0] a);
    return {a, ~a} ^ mem_seed;
  endfunction

  always @(posedge clk) imem_q <= mem_fn(imem_a);

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int n_deliv = 0;
  int hs_cnt = 0;
  int stall_cnt = 0;

  // Reference model: after reset or redirect, decode must see the word
  // addresses start, start+1, ... (mod 2^ADDR) in order, each with its
  // memory contents, with nothing lost or repeated.
  logic [ADDR-1:0] exp_q[$];
  logic [ADDR-1:0] seg_next;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic top_up();
    while (exp_q.size() < 16) begin
      exp_q.push_back(seg_next);
      seg_next = seg_next + 1'b1;
    end
  endtask

  task automatic start_seg(input logic [ADDR-1:0] start);
    exp_q.delete();
    seg_next = start;
    top_up();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    top_up();
  endtask

  // ---------------- monitor ----------------
  logic            prev_stall = 1'b0;
  logic            prev_flush = 1'b1;
  logic [ADDR-1:0] held_pc;
  logic [WORD-1:0] held_data;

  always @(negedge clk) begin
    logic [ADDR-1:0] e;
    if (rst) begin
      hs_cnt    = 0;
      stall_cnt = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && !prev_flush) begin
        chk("hold_valid", inst_valid, 1'b1);
        chk("hold_pc", inst_pc, held_pc);
        chk("hold_data", inst_data, held_data);
      end
      if (inst_valid && inst_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL deliver_unexpected actual pc=%0h required none", inst_pc);
        end else begin
          e = exp_q.pop_front();
          if (inst_pc !== e || inst_data !== mem_fn(e)) begin
            errors++;
            $display("FAIL deliver actual pc=%0h data=%0h required pc=%0h data=%0h",
                     inst_pc, inst_data, e, mem_fn(e));
          end
        end
        n_deliv++;
        hs_cnt++;
      end
      if (inst_valid && !inst_ready) stall_cnt++;
      prev_stall = inst_valid && !inst_ready;
      held_pc    = inst_pc;
      held_data  = inst_data;
    end
    prev_flush = redirect_valid || rst;
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver ----------------
  logic            pend_rst;
  logic            pend_redir;
  logic [ADDR-1:0] pend_tgt;
  logic [ADDR-1:0] halt_a;
  int              r;

  initial begin
    mem_seed       = $urandom;
    rst            = 1'b1;
    halt           = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b0;
    seg_next       = RST_A;

    // Reset values
    step();
    step();
    @(negedge clk);
    chk("rst_valid", inst_valid, 1'b0);
    chk("rst_data", inst_data, 32'h0);
    chk("rst_pc", inst_pc, 16'h0);
    chk("rst_imem_a", imem_a, RST_A);
    chk("rst_imem_w", imem_w, 1'b0);

    // First fetch latency, wrap past 2^ADDR-1, full throughput
    step();
    rst        = 1'b0;
    inst_ready = 1'b1;
    start_seg(RST_A);
    @(negedge clk); chk("lat_c0_valid", inst_valid, 1'b0);
    @(negedge clk); chk("lat_c1_valid", inst_valid, 1'b0);
    @(negedge clk); chk("lat_c2_valid", inst_valid, 1'b1);
    chk("lat_c2_pc", inst_pc, RST_A);
    chk("lat_c2_data", inst_data, mem_fn(RST_A));
    @(negedge clk); chk("tput_c3_valid", inst_valid, 1'b1);
    chk("tput_c3_pc", inst_pc, 16'hFFFF);
    @(negedge clk); chk("tput_c4_valid", inst_valid, 1'b1);
    chk("tput_c4_pc", inst_pc, 16'h0000);
    @(negedge clk); chk("tput_c5_pc", inst_pc, 16'h0001);

    // Reset mid-stream, then back-pressure from the first word
    step();
    rst = 1'b1;
    step();
    rst        = 1'b0;
    inst_ready = 1'b0;
    start_seg(RST_A);
    @(negedge clk); chk("rst_mid_valid", inst_valid, 1'b0);
    repeat (6) step();
    @(negedge clk);
    chk("bp_valid", inst_valid, 1'b1);
    chk("bp_head_pc", inst_pc, RST_A);
    chk("bp_credit_limit", imem_a, 16'h0000);
    step();
    inst_ready = 1'b1;
    repeat (10) step();

    // Redirect with words buffered and one read in flight
    inst_ready = 1'b0;
    repeat (4) step();
    inst_ready = 1'b1;
    step();
    inst_ready     = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0040;
    step();
    redirect_valid = 1'b0;
    inst_ready     = 1'b1;
    start_seg(16'h0040);
    @(negedge clk); chk("redir_r1_valid", inst_valid, 1'b0);
    @(negedge clk); chk("redir_r2_valid", inst_valid, 1'b0);
    @(negedge clk); chk("redir_r3_valid", inst_valid, 1'b1);
    chk("redir_r3_pc", inst_pc, 16'h0040);
    repeat (5) step();

    // Redirect coincident with the handshake of pc 5
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0003;
    step();
    redirect_valid = 1'b0;
    start_seg(16'h0003);
    repeat (4) step();
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0100;
    @(negedge clk);
    chk("coinc_valid", inst_valid, 1'b1);
    chk("coinc_pc", inst_pc, 16'h0005);
    step();
    redirect_valid = 1'b0;
    start_seg(16'h0100);
    repeat (8) step();

    // Halt one cycle after an issue; the in-flight word still arrives
    halt = 1'b1;
    @(negedge clk);
    halt_a = imem_a;
    repeat (6) step();
    @(negedge clk);
    chk("halt_pc_frozen", imem_a, halt_a);
    chk("halt_drained", inst_valid, 1'b0);
    step();
    halt = 1'b0;
    repeat (6) step();

    // Redirect while halted, resume when halt drops
    halt = 1'b1;
    repeat (3) step();
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0200;
    step();
    redirect_valid = 1'b0;
    start_seg(16'h0200);
    repeat (3) step();
    @(negedge clk);
    chk("halt_redir_pc", imem_a, 16'h0200);
    chk("halt_redir_valid", inst_valid, 1'b0);
    step();
    halt = 1'b0;
    repeat (6) step();

    // Randomized traffic
    pend_rst   = 1'b0;
    pend_redir = 1'b0;
    pend_tgt   = '0;
    for (int c = 0; c < 1500; c++) begin
      step();
      if (pend_rst) start_seg(RST_A);
      else if (pend_redir) start_seg(pend_tgt);
      pend_rst       = 1'b0;
      pend_redir     = 1'b0;
      rst            = 1'b0;
      redirect_valid = 1'b0;
      inst_ready     = ($urandom_range(0, 3) != 0);
      halt           = ($urandom_range(0, 9) == 0);
      r = $urandom_range(0, 199);
      if (r == 0) begin
        rst      = 1'b1;
        pend_rst = 1'b1;
      end else if (r < 9) begin
        redirect_valid = 1'b1;
        redirect_pc    = ADDR'($urandom);
        pend_tgt       = redirect_pc;
        pend_redir     = 1'b1;
      end
    end
    step();
    if (pend_rst) start_seg(RST_A);
    else if (pend_redir) start_seg(pend_tgt);
    rst            = 1'b0;
    redirect_valid = 1'b0;
    halt           = 1'b0;
    inst_ready     = 1'b1;
    repeat (8) step();
    inst_ready = 1'b0;
    repeat (3) step();

`ifdef INST_FETCH_PERF_EN
    chk("perf_fetched", perf_fetched, hs_cnt);
    chk("perf_stall", perf_stall, stall_cnt);
`endif
    chk("deliveries_seen", (n_deliv > 300), 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
